// File: rtl/mc_controller.sv
// ============================================================================
// Module  : mc_controller
// Purpose : Multicycle ARM control unit with main FSM, instruction decoder and
//           conditional-execution logic for ADD/SUB/AND/ORR, LDR/STR and B.
// Option  : MC_CTRL_CMP_EN adds CMP (cmd 1010, S=1) as a flag-only SUB.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_UNKNOWN = 4'd10;

  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] r_flags;
  logic       r_condex;

  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [3:0] w_rd;
  logic       w_dp_ok;
  logic       w_is_cmp;
  logic       w_cond_ok;
  logic       w_exec;
  logic [1:0] w_flagw;

  logic       w_nextpc;
  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_irw;
  logic       w_pcs;
  logic       w_unused_bits;

  assign w_op    = Instr[27:26];
  assign w_funct = Instr[25:20];
  assign w_cmd   = w_funct[4:1];
  assign w_s     = w_funct[0];
  assign w_rd    = Instr[15:12];
  assign w_unused_bits = ^{Instr[19:16], Instr[11:0]};

  assign w_dp_ok = (w_cmd == c_CMD_ADD) || (w_cmd == c_CMD_SUB) ||
                   (w_cmd == c_CMD_AND) || (w_cmd == c_CMD_ORR);

`ifdef MC_CTRL_CMP_EN
  assign w_is_cmp = (w_cmd == c_CMD_CMP) && w_s;
`else
  assign w_is_cmp = 1'b0;
`endif

  // Condition evaluated against the registered flags only, never ALUFlags
  always_comb begin
    w_cond_ok = 1'b0;
    case (Instr[31:28])
      4'b0000: w_cond_ok = r_flags[2];
      4'b0001: w_cond_ok = ~r_flags[2];
      4'b0010: w_cond_ok = r_flags[1];
      4'b0011: w_cond_ok = ~r_flags[1];
      4'b0100: w_cond_ok = r_flags[3];
      4'b0101: w_cond_ok = ~r_flags[3];
      4'b0110: w_cond_ok = r_flags[0];
      4'b0111: w_cond_ok = ~r_flags[0];
      4'b1000: w_cond_ok = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ok = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_ok = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_ok = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_exec     = (r_state == S_EXECR) || (r_state == S_EXECI);
  assign w_flagw[1] = w_exec & w_s;
  assign w_flagw[0] = w_exec & w_s &
                      ((w_cmd == c_CMD_ADD) || (w_cmd == c_CMD_SUB) || w_is_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags  <= FLAGS_RST;
      r_condex <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_condex <= w_cond_ok;
      end
      if (r_condex && w_flagw[1]) begin
        r_flags[3:2] <= ALUFlags[3:2];
      end
      if (r_condex && w_flagw[0]) begin
        r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = (w_dp_ok || w_is_cmp) ?
                            (w_funct[5] ? S_EXECI : S_EXECR) : S_UNKNOWN;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:  w_next = w_is_cmp ? S_FETCH : S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_nextpc   = 1'b0;
    w_branch   = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = 1'b1;
        w_nextpc  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR,
      S_EXECI: begin
        ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        case (w_cmd)
          c_CMD_SUB: ALUControl = 2'b01;
          c_CMD_AND: ALUControl = 2'b10;
          c_CMD_ORR: ALUControl = 2'b11;
          c_CMD_CMP: ALUControl = 2'b01;
          default:   ALUControl = 2'b00;
        endcase
      end
      S_ALUWB:  w_regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_pcs     = w_branch | (w_regw & (w_rd == 4'hF));
  assign PCWrite   = reset & (w_nextpc | (w_pcs & r_condex));
  assign RegWrite  = reset & w_regw & r_condex;
  assign MemWrite  = reset & w_memw & r_condex;
  assign IRWrite   = reset & w_irw;
  assign RegSrc[0] = (w_op == 2'b10);
  assign RegSrc[1] = (w_op == 2'b01) & ~w_funct[0];
  assign ImmSrc    = w_op;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module  : tb_mc_controller
// Purpose : Scoreboard bench for mc_controller; per-cycle expected control
//           vectors are queued by the stimulus and checked by a monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  mc_controller #(.FLAGS_RST(4'b0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  typedef struct {
    string       nm;
    logic [16:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  string       g_nm;
  logic [1:0]  g_rs;
  logic [1:0]  g_im;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: PCW MemW RegW IRW AdrSrc RegSrc ALUSrcA ALUSrcB ResultSrc ImmSrc ALUControl
  always @(negedge clk) begin
    logic [16:0] act;
    exp_t        e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
      end
    end
  end

  function automatic logic [16:0] pk(input logic pcw, input logic mw, input logic rw,
                                     input logic irw, input logic adr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] res, input logic [1:0] alu);
    return {pcw, mw, rw, irw, adr, g_rs, sa, sb, res, g_im, alu};
  endfunction

  task automatic push(input string st, input logic [16:0] v);
    exp_t e;
    e.nm = {g_nm, "/", st};
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input string nm, input logic [31:0] ins, input logic [3:0] af,
                       input logic [1:0] rs, input logic [1:0] im);
    Instr    = ins;
    ALUFlags = af;
    g_nm     = nm;
    g_rs     = rs;
    g_im     = im;
    push("FETCH",  pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
    push("DECODE", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
  endtask

  task automatic dp(input string nm, input logic [31:0] ins, input logic [3:0] af,
                    input logic imm, input logic [1:0] alu, input logic pcw, input logic rw);
    start(nm, ins, af, 2'b00, 2'b00);
    push("EXEC",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, imm ? 2'b01 : 2'b00, 2'b00, alu));
    push("ALUWB", pk(pcw, 1'b0, rw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    run(4);
  endtask

  task automatic ldr(input string nm, input logic [31:0] ins, input logic rw);
    start(nm, ins, 4'b0000, 2'b00, 2'b01);
    push("MEMADR", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00));
    push("MEMRD",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
    push("MEMWB",  pk(1'b0, 1'b0, rw,   1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00));
    run(5);
  endtask

  task automatic str(input string nm, input logic [31:0] ins, input logic mw);
    start(nm, ins, 4'b0000, 2'b10, 2'b01);
    push("MEMADR", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00));
    push("MEMWR",  pk(1'b0, mw,   1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
    run(4);
  endtask

  task automatic br(input string nm, input logic [31:0] ins, input logic pcw);
    start(nm, ins, 4'b0000, 2'b01, 2'b10);
    push("BRANCH", pk(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00));
    run(3);
  endtask

  task automatic unk(input string nm, input logic [31:0] ins, input logic [3:0] af,
                     input logic [1:0] im);
    start(nm, ins, af, 2'b00, im);
    push("UNKNOWN", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    run(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'b0000;
    g_nm     = "RESET";
    g_rs     = 2'b00;
    g_im     = 2'b00;
    @(posedge clk);
    #1;
    // Reset holds FETCH selects but every enable must be low
    push("HOLD0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
    push("HOLD1", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
    run(2);
    reset = 1'b1;

    dp("SUBS",    32'hE052_1002, 4'b0110, 1'b0, 2'b01, 1'b0, 1'b1);  // flags -> 0110
    dp("ADDEQ_z1", 32'h0280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
    dp("ADDNE_z1", 32'h1280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    dp("ANDS",    32'hE012_1003, 4'b0000, 1'b0, 2'b10, 1'b0, 1'b1);  // NZ -> 00, CV kept 10
    dp("ADDCS",   32'h2280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
    dp("ADDEQ_z0", 32'h0280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    ldr("LDR",    32'hE590_4008, 1'b1);
    str("STR_AL", 32'hE580_4008, 1'b1);
    dp("SUBS2",   32'hE052_1002, 4'b0110, 1'b0, 2'b01, 1'b0, 1'b1);  // flags -> 0110
    str("STRNE",  32'h1580_4008, 1'b0);
    br("B_AL",    32'hEA00_0010, 1'b1);
    dp("ADDS",    32'hE290_1001, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1);  // flags -> 1001
    br("BEQ_z0",  32'h0A00_0010, 1'b0);
    dp("ADDGE",   32'hA280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
    dp("ADDLT",   32'hB280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    dp("ADD_NV",  32'hF280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
    dp("ADD_PC",  32'hE280_F020, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b1);
    unk("OP11",   32'hEC00_0000, 4'b0000, 2'b11);
    unk("EOR",    32'hE020_1002, 4'b0110, 2'b00);

`ifdef MC_CTRL_CMP_EN
    start("CMP", 32'hE351_0003, 4'b0110, 2'b00, 2'b00);
    push("EXEC", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01));
    run(3);
    dp("ADDEQ_cmp", 32'h0280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1);
`else
    unk("CMP", 32'hE351_0003, 4'b0110, 2'b00);
    dp("ADDEQ_cmp", 32'h0280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);
`endif

    dp("SUBS3", 32'hE052_1002, 4'b0110, 1'b0, 2'b01, 1'b0, 1'b1);  // Z=1 before reset

    // Reset asserted in the middle of MEMRD
    start("LDR_RST", 32'hE590_4008, 4'b0000, 2'b00, 2'b01);
    push("MEMADR", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00));
    push("MEMRD",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
    run(3);
    @(negedge clk);
    #1;
    reset = 1'b0;
    push("RST_HOLD", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
    run(2);
    reset = 1'b1;
    dp("ADDEQ_rst", 32'h0280_3001, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0);

    run(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
